// File: rtl/soc_int_source_conditioner_if.sv
// Interrupt source conditioner signal bundle: raw lines and enables in,
// conditioned triggers and debounced levels out.
interface soc_int_source_conditioner_if;
  logic [31:0] raw_src;
  logic [31:0] chan_en;
  logic [31:0] int_triggers;
  logic [31:0] filt_levels;

  modport master (
    output raw_src,
    output chan_en,
    input  int_triggers,
    input  filt_levels
  );

  modport slave (
    input  raw_src,
    input  chan_en,
    output int_triggers,
    output filt_levels
  );
endinterface

// File: rtl/soc_int_source_conditioner.sv
// Interrupt source conditioner: per-channel synchroniser, debounce filter
// and registered edge/level detection feeding the SoC interrupt controller.
module soc_int_source_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [63:0] CHAN_MODE       = 64'h5555_5555_5555_5555
) (
  input logic                         clk,
  input logic                         res_n,
  soc_int_source_conditioner_if.slave bus
);

  localparam int unsigned NCH = 32;
  localparam int unsigned CW  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned WW  = $clog2(SYNC_STAGES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WARM_INIT = WW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_LEVEL = 2'b11
  } chan_mode_e;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } phase_e;

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] sync_cur;
  logic [NCH-1:0] sync_next;

  assign sync_cur  = sync_q[SYNC_STAGES-1];
  // Value the last synchroniser flop loads on this edge; tracking channels
  // take it so that filt equals sync right after the clock.
  assign sync_next = sync_q[SYNC_STAGES-2];

  // Shift raw lines through the synchroniser flops
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus.raw_src;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up phase after reset release
  // ---------------------------------------------------------------------------
  phase_e         phase_q;
  phase_e         phase_d;
  logic [WW-1:0]  warm_cnt_q;
  logic [WW-1:0]  warm_cnt_d;
  logic           warm;

  // Phase and warm-up counter registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      phase_q    <= ST_WARM;
      warm_cnt_q <= WARM_INIT;
    end else begin
      phase_q    <= phase_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Count down SYNC_STAGES clocks, then run
  always_comb begin
    phase_d    = phase_q;
    warm_cnt_d = warm_cnt_q;
    warm       = 1'b0;
    case (phase_q)
      ST_WARM: begin
        warm       = 1'b1;
        warm_cnt_d = warm_cnt_q - WW'(1);
        if (warm_cnt_q == WW'(1)) begin
          phase_d = ST_RUN;
        end
      end
      ST_RUN: begin
        phase_d = ST_RUN;
      end
      default: begin
        phase_d = ST_WARM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Debounce filter and trigger detection
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] filt_q;
  logic [NCH-1:0] filt_d;
  logic [NCH-1:0] seen_q;   // filt level last presented to the edge detector
  logic [NCH-1:0] seen_d;
  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] trig_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  assign bus.filt_levels  = filt_q;
  assign bus.int_triggers = trig_q;

  // Filter, edge-history and trigger registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      filt_q <= '0;
      seen_q <= '0;
      trig_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      seen_q <= seen_d;
      trig_q <= trig_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-channel filter update and registered edge/level detection
  always_comb begin
    filt_d = filt_q;
    seen_d = seen_q;
    trig_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
    end

    for (int unsigned i = 0; i < NCH; i++) begin
      if (warm || !bus.chan_en[i]) begin
        // Silent tracking: the detector history is aligned with the new
        // level so re-enabling or leaving warm-up never yields a stale edge.
        filt_d[i] = sync_next[i];
        seen_d[i] = sync_next[i];
      end else begin
        seen_d[i] = filt_q[i];
        if (DEBOUNCE_CYCLES == 0) begin
          filt_d[i] = sync_cur[i];
        end else if (sync_cur[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_cur[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end

        case (chan_mode_e'(CHAN_MODE[2*i +: 2]))
          MODE_RISE:  trig_d[i] = filt_q[i] & ~seen_q[i];
          MODE_FALL:  trig_d[i] = ~filt_q[i] & seen_q[i];
          MODE_LEVEL: trig_d[i] = filt_q[i];
          default:    trig_d[i] = 1'b0;
        endcase
      end
    end
  end

endmodule
